// File: rtl/led_cube_scan_controller.sv
// led_cube_scan_controller
//
// Purpose: scans a multi-panel LED cube. A double-buffered frame store
// (one RAM per panel per bank) is written by the host into the back bank.
// The front bank is shifted out to the LED driver chains one PWM slot at a
// time. Each slot is a LOAD, a serial SHIFT of every LED and a LATCH. A
// BLANK gap follows every row change. Bank swaps are only taken at frame
// boundaries, so a half-written frame is never shown.
//
// Ports:
//   clk, reset_n     single clock, asynchronous active-low reset
//   wr_en/addr/data  pixel write into the back bank; addr = {panel,row,led},
//                    data = {R,G,B}
//   swap_req         request to show the back bank at the next boundary
//   swap_pending     a swap has been requested but not yet taken
//   frame_start      one-cycle pulse in the frame boundary cycle
//   serial_clk       driver shift clock
//   latch_enable     driver latch strobe
//   output_enable_n  driver output enable, active low
//   serial_data_out  {R,G,B} lanes per panel, panel i at [3i+2:3i]
//   row_select_n     one-hot-low row drive
module led_cube_scan_controller #(
    parameter int NUM_PANELS   = 4,
    parameter int NUM_ROWS     = 16,
    parameter int LEDS_PER_ROW = 16,
    parameter int PWM_BITS     = 8,
    parameter int BLANK_CYCLES = 8,
    localparam int AW = $clog2(NUM_PANELS * NUM_ROWS * LEDS_PER_ROW)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [3*PWM_BITS-1:0]   wr_data,
    input  logic                    swap_req,
    output logic                    swap_pending,
    output logic                    frame_start,
    output logic                    serial_clk,
    output logic                    latch_enable,
    output logic                    output_enable_n,
    output logic [3*NUM_PANELS-1:0] serial_data_out,
    output logic [NUM_ROWS-1:0]     row_select_n
);

    localparam int PW        = $clog2(NUM_PANELS);
    localparam int RW        = $clog2(NUM_ROWS);
    localparam int LW        = $clog2(LEDS_PER_ROW);
    localparam int DW        = 3 * PWM_BITS;
    localparam int DEPTH     = NUM_ROWS * LEDS_PER_ROW;
    localparam int SHIFT_LEN = 2 * LEDS_PER_ROW;
    localparam int CNT_MAX   = (SHIFT_LEN > BLANK_CYCLES) ? SHIFT_LEN : BLANK_CYCLES;
    localparam int CW        = $clog2(CNT_MAX) + 1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_BLANK
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [RW-1:0]           row_q, row_d;
    logic [PWM_BITS-1:0]     slot_q, slot_d;
    logic                    front_bank_q, front_bank_d;
    logic                    swap_pending_q, swap_pending_d;
    logic                    armed_q, armed_d;
    logic                    frame_start_q, frame_start_d;
    logic                    sclk_q, sclk_d;
    logic                    latch_q, latch_d;
    logic                    oe_n_q, oe_n_d;
    logic [3*NUM_PANELS-1:0] sdata_q, sdata_d;
    logic [NUM_ROWS-1:0]     row_sel_q, row_sel_d;

    logic [DW-1:0]           mem [2][NUM_PANELS][DEPTH];
    logic [LW-1:0]           rd_led;
    logic [DW-1:0]           rd_word;
    logic [3*NUM_PANELS-1:0] rd_bits;

    // Frame store. Host writes always target the bank not being displayed.
    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[~front_bank_q][wr_addr[AW-1 -: PW]][wr_addr[RW+LW-1:0]] <= wr_data;
        end
    end

    // Sequencer next state, counters, swap handling and registered output
    // values. Outputs are computed from the next state so that each
    // registered output lines up with the state it belongs to.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        row_d          = row_q;
        slot_d         = slot_q;
        front_bank_d   = front_bank_q;
        swap_pending_d = swap_pending_q | swap_req;
        armed_d        = armed_q;
        frame_start_d  = 1'b0;
        row_sel_d      = row_sel_q;

        case (state_q)
            S_LOAD: begin
                state_d = S_SHIFT;
                cnt_d   = '0;
            end
            S_SHIFT: begin
                if (cnt_q == CW'(SHIFT_LEN - 1)) begin
                    state_d = S_LATCH;
                    cnt_d   = '0;
                    // The row drive changes together with the latch of slot 0.
                    if (slot_q == '0) begin
                        row_sel_d         = '1;
                        row_sel_d[row_q]  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (slot_q == '1) begin
                    slot_d        = '0;
                    row_d         = row_q + 1'b1;
                    frame_start_d = (row_q == '1);
                end else begin
                    slot_d = slot_q + 1'b1;
                end
                if (slot_q == '0) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_BLANK: begin
                if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                    state_d = S_LOAD;
                    armed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_LOAD;
        endcase

        // frame_start_q marks the boundary cycle; a request in that very
        // cycle is honoured without ever raising swap_pending.
        if (frame_start_q && (swap_pending_q || swap_req)) begin
            front_bank_d   = ~front_bank_q;
            swap_pending_d = 1'b0;
        end

        sclk_d  = (state_d == S_SHIFT) && cnt_d[0];
        latch_d = (state_d == S_LATCH);
        oe_n_d  = !(armed_d && ((state_d == S_LOAD) || (state_d == S_SHIFT)));
    end

    // Pixel fetch and PWM compare. The read is addressed from the next-state
    // counter and bank so the compare result is registered straight into
    // serial_data_out for the following even shift cycle. LEDs go out from
    // the highest index down, which for a power-of-two row is the bitwise
    // inverse of the LED pair number.
    always_comb begin
        rd_led  = ~cnt_d[LW:1];
        rd_word = '0;
        rd_bits = '0;
        for (int p = 0; p < NUM_PANELS; p++) begin
            rd_word = mem[front_bank_d][PW'(p)][{row_q, rd_led}];
            rd_bits[3*p+2] = rd_word[3*PWM_BITS-1:2*PWM_BITS] > slot_q;
            rd_bits[3*p+1] = rd_word[2*PWM_BITS-1:PWM_BITS] > slot_q;
            rd_bits[3*p]   = rd_word[PWM_BITS-1:0] > slot_q;
        end

        if (state_d == S_SHIFT) begin
            sdata_d = cnt_d[0] ? sdata_q : rd_bits;
        end else begin
            sdata_d = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_LOAD;
            cnt_q          <= '0;
            row_q          <= '0;
            slot_q         <= '0;
            front_bank_q   <= 1'b0;
            swap_pending_q <= 1'b0;
            armed_q        <= 1'b0;
            frame_start_q  <= 1'b0;
            sclk_q         <= 1'b0;
            latch_q        <= 1'b0;
            oe_n_q         <= 1'b1;
            sdata_q        <= '0;
            row_sel_q      <= '1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            row_q          <= row_d;
            slot_q         <= slot_d;
            front_bank_q   <= front_bank_d;
            swap_pending_q <= swap_pending_d;
            armed_q        <= armed_d;
            frame_start_q  <= frame_start_d;
            sclk_q         <= sclk_d;
            latch_q        <= latch_d;
            oe_n_q         <= oe_n_d;
            sdata_q        <= sdata_d;
            row_sel_q      <= row_sel_d;
        end
    end

    assign swap_pending    = swap_pending_q;
    assign frame_start     = frame_start_q;
    assign serial_clk      = sclk_q;
    assign latch_enable    = latch_q;
    assign output_enable_n = oe_n_q;
    assign serial_data_out = sdata_q;
    assign row_select_n    = row_sel_q;

endmodule

// File: tb/tb_led_cube_scan_controller.sv
// tb_led_cube_scan_controller
//
// Directed bench for led_cube_scan_controller with 2 panels, 2 rows,
// 4 LEDs per row, 2 PWM bits and 3 blank cycles (slot 10 cycles, row 43,
// frame 86). Cycle 0 is the first cycle after reset release; outputs are
// sampled on the falling clock edge and inputs are driven there too.
module tb_led_cube_scan_controller;

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [5:0] wr_data;
    logic       swap_req;
    logic       swap_pending;
    logic       frame_start;
    logic       serial_clk;
    logic       latch_enable;
    logic       output_enable_n;
    logic [5:0] serial_data_out;
    logic [1:0] row_select_n;

    int cyc;
    int checkCount;
    int passCount;
    int failCount;

    led_cube_scan_controller #(
        .NUM_PANELS   (2),
        .NUM_ROWS     (2),
        .LEDS_PER_ROW (4),
        .PWM_BITS     (2),
        .BLANK_CYCLES (3)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .swap_req        (swap_req),
        .swap_pending    (swap_pending),
        .frame_start     (frame_start),
        .serial_clk      (serial_clk),
        .latch_enable    (latch_enable),
        .output_enable_n (output_enable_n),
        .serial_data_out (serial_data_out),
        .row_select_n    (row_select_n)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount = checkCount + 1;
        assert (observed === expected) passCount = passCount + 1;
        else begin
            failCount = failCount + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to the sample point of the given cycle.
    task automatic gotoCycle(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc = cyc + 1;
        end
    endtask

    // Drive one cycle of host inputs, then return them to idle.
    task automatic applyStimulus(input logic we, input logic [3:0] addr,
                                 input logic [5:0] data, input logic swap);
        wr_en    = we;
        wr_addr  = addr;
        wr_data  = data;
        swap_req = swap;
        gotoCycle(cyc + 1);
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        swap_req = 1'b0;
    endtask

    // Release reset just after a rising edge; cycle 0 is sampled next.
    task automatic releaseReset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        cyc = 0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " oe_n"}, output_enable_n, 1'b1);
        checkOutput({tag, " row_sel"}, row_select_n, 2'b11);
        checkOutput({tag, " sdata"}, serial_data_out, 6'h00);
        checkOutput({tag, " sclk"}, serial_clk, 1'b0);
        checkOutput({tag, " latch"}, latch_enable, 1'b0);
        checkOutput({tag, " fstart"}, frame_start, 1'b0);
        checkOutput({tag, " pending"}, swap_pending, 1'b0);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        cyc        = 0;
        reset_n    = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        swap_req   = 1'b0;

        // Reset state while reset is held.
        repeat (3) @(negedge clk);
        checkResetOutputs("in_reset");
        releaseReset();

        // Clear both banks so the RAM starts from a known picture.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 4'(i), 6'h00, 1'b0);
        applyStimulus(1'b0, 4'h0, 6'h00, 1'b1);
        checkOutput("prep pending rise", swap_pending, 1'b1);
        gotoCycle(86);
        checkOutput("prep boundary fstart", frame_start, 1'b1);
        checkOutput("prep pending at boundary", swap_pending, 1'b1);
        gotoCycle(87);
        checkOutput("prep pending fall", swap_pending, 1'b0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 4'(i), 6'h00, 1'b0);

        // Fresh reset with no writes: scan timing from cycle 0.
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        releaseReset();
        checkOutput("c0 oe_n", output_enable_n, 1'b1);
        gotoCycle(1);
        checkOutput("c1 sclk", serial_clk, 1'b0);
        checkOutput("c1 sdata", serial_data_out, 6'h00);
        gotoCycle(2);
        checkOutput("c2 sclk", serial_clk, 1'b1);
        gotoCycle(8);
        checkOutput("c8 row_sel", row_select_n, 2'b11);
        gotoCycle(9);
        checkOutput("c9 row_sel", row_select_n, 2'b10);
        checkOutput("c9 latch", latch_enable, 1'b1);
        checkOutput("c9 oe_n", output_enable_n, 1'b1);
        gotoCycle(12);
        checkOutput("c12 oe_n", output_enable_n, 1'b1);
        gotoCycle(13);
        checkOutput("c13 oe_n", output_enable_n, 1'b0);
        gotoCycle(52);
        checkOutput("c52 row_sel", row_select_n, 2'b01);
        gotoCycle(85);
        checkOutput("c85 fstart", frame_start, 1'b0);
        gotoCycle(86);
        checkOutput("c86 fstart", frame_start, 1'b1);
        gotoCycle(87);
        checkOutput("c87 fstart", frame_start, 1'b0);

        // Panel 0, row 0, led 3 = {R=3,G=1,B=0} into the back bank only.
        gotoCycle(88);
        applyStimulus(1'b1, 4'b0011, 6'h34, 1'b0);
        for (int f = 2; f <= 4; f++) begin
            gotoCycle(86 * f);
            checkOutput("noswap fstart", frame_start, 1'b1);
            gotoCycle(86 * f + 1);
            checkOutput("noswap sdata", serial_data_out, 6'h00);
            checkOutput("noswap pending", swap_pending, 1'b0);
        end

        // Three requests in one frame give exactly one swap at 430.
        gotoCycle(350);
        applyStimulus(1'b0, 4'h0, 6'h00, 1'b1);
        checkOutput("multi pending rise", swap_pending, 1'b1);
        gotoCycle(360);
        applyStimulus(1'b0, 4'h0, 6'h00, 1'b1);
        gotoCycle(370);
        applyStimulus(1'b0, 4'h0, 6'h00, 1'b1);
        checkOutput("multi pending held", swap_pending, 1'b1);
        gotoCycle(430);
        checkOutput("multi fstart", frame_start, 1'b1);
        checkOutput("multi pending at boundary", swap_pending, 1'b1);
        gotoCycle(431);
        checkOutput("multi pending fall", swap_pending, 1'b0);
        checkOutput("slot0 led3", serial_data_out, 6'h06);
        gotoCycle(432);
        checkOutput("slot0 sclk", serial_clk, 1'b1);
        checkOutput("slot0 led3 held", serial_data_out, 6'h06);
        gotoCycle(433);
        checkOutput("slot0 led2", serial_data_out, 6'h00);
        gotoCycle(444);
        checkOutput("slot1 led3", serial_data_out, 6'h04);
        gotoCycle(454);
        checkOutput("slot2 led3", serial_data_out, 6'h04);
        gotoCycle(464);
        checkOutput("slot3 led3", serial_data_out, 6'h00);
        gotoCycle(517);
        checkOutput("next frame same bank", serial_data_out, 6'h06);

        // Request exactly in the boundary cycle: immediate swap to bank 0.
        gotoCycle(602);
        checkOutput("edge fstart", frame_start, 1'b1);
        checkOutput("edge pending before", swap_pending, 1'b0);
        applyStimulus(1'b0, 4'h0, 6'h00, 1'b1);
        checkOutput("edge pending after", swap_pending, 1'b0);
        checkOutput("edge swapped sdata", serial_data_out, 6'h00);

        // Swap back to bank 1, then put a panel 1 pixel into bank 0.
        gotoCycle(610);
        applyStimulus(1'b0, 4'h0, 6'h00, 1'b1);
        gotoCycle(689);
        checkOutput("swap back sdata", serial_data_out, 6'h06);
        gotoCycle(690);
        applyStimulus(1'b1, 4'b1011, 6'h09, 1'b0);

        // Reset in the middle of row 1's shift.
        gotoCycle(735);
        checkOutput("pre reset sclk", serial_clk, 1'b1);
        checkOutput("pre reset oe_n", output_enable_n, 1'b0);
        reset_n = 1'b0;
        #1;
        checkResetOutputs("mid reset");
        repeat (2) @(negedge clk);
        releaseReset();
        checkOutput("restart pending", swap_pending, 1'b0);
        gotoCycle(1);
        checkOutput("restart slot0", serial_data_out, 6'h18);
        gotoCycle(9);
        checkOutput("restart row_sel", row_select_n, 2'b10);
        gotoCycle(14);
        checkOutput("restart slot1", serial_data_out, 6'h10);
        gotoCycle(24);
        checkOutput("restart slot2", serial_data_out, 6'h00);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
